div_bcd_conv: RTL and testbench

DIV_BCD_CONV -- requirements
Module: div_bcd_conv

---
 rtl/div_bcd_pkg.sv | 23 ++
 rtl/div_res_fifo.sv | 53 +++++
 rtl/div_bcd_conv.sv | 189 ++++++++++++++++++
 tb/tb_div_bcd_conv.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_bcd_pkg.sv
// Shared types and sizing helpers for the divider-result BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_bcd_pkg;

  // Converter control states: wait for work, run double-dabble, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed for an n-bit quotient (77/256 ~ log10(2)).
  function automatic int qd_digits(input int n);
    return (n * 77) / 256 + 1;
  endfunction

  // Decimal digits needed for an m-bit remainder.
  function automatic int rd_digits(input int m);
    return (m * 77) / 256 + 1;
  endfunction

endpackage

// File: rtl/div_res_fifo.sv
// Small FIFO holding divider results waiting for BCD conversion.
// Latency: an entry written at an edge is visible at the head (fall-through) right after it.
// Backpressure: none upstream; a write while full is refused, full tells the caller.
module div_res_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_rdy,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push   = i_wr_vld && !full;
  assign w_pop    = i_rd_rdy && !empty;
  assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end
  end

  // Read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/div_bcd_conv.sv
// Converts divider quotient/remainder pairs to packed BCD via double-dabble (optional DIV_BCD_DROP_CNT_EN adds drop_cnt).
// Latency: result sampled at edge k is presented after edge k+N+2; one result per N+2 cycles.
// Backpressure: bcd_vld/bcd_rdy hold the result; none upstream, overflowing results are dropped and flag ovf.
module div_bcd_conv
  import div_bcd_pkg::*;
#(
  parameter int  N     = 8,
  parameter int  M     = 5,
  parameter int  DEPTH = 4,
  localparam int QD    = qd_digits(N),
  localparam int RD    = rd_digits(M)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            res_rdy,
  input  logic [N-1:0]    merchant,
  input  logic [M-1:0]    remainder,
  output logic            bcd_vld,
  input  logic            bcd_rdy,
  output logic [4*QD-1:0] bcd_quo,
  output logic [4*RD-1:0] bcd_rem,
`ifdef DIV_BCD_DROP_CNT_EN
  output logic [7:0]      drop_cnt,
`endif
  output logic            ovf
);

  localparam int WD = N + M;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic            r_in_vld;
  logic [WD-1:0]   r_in_dat;
  logic            w_full;
  logic            w_empty;
  logic [WD-1:0]   w_head;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_shift;
  logic            w_last;

  logic [N-1:0]    r_qbin;
  logic [N-1:0]    r_rbin;
  logic [4*QD-1:0] r_quo_acc;
  logic [4*QD-1:0] w_quo_adj;
  logic [4*QD-1:0] w_quo_shf;
  logic [4*RD-1:0] r_rem_acc;
  logic [4*RD-1:0] w_rem_adj;
  logic [4*RD-1:0] w_rem_shf;
  logic [CW-1:0]   r_cnt;
  logic [4*QD-1:0] r_bcd_quo;
  logic [4*RD-1:0] r_bcd_rem;
  logic            r_ovf;

  // Capture stage in front of the FIFO; a pulse seen during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_in_vld <= 1'b0;
      r_in_dat <= '0;
    end else begin
      r_in_vld <= res_rdy;
      r_in_dat <= {merchant, remainder};
    end
  end

  div_res_fifo #(
    .WIDTH (WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .i_wr_vld (r_in_vld),
    .i_wr_dat (r_in_dat),
    .i_rd_rdy (w_load),
    .o_rd_dat (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Sticky drop flag: a write into a full FIFO is lost even if a pop happens that cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (r_in_vld && w_full) begin
      r_ovf <= 1'b1;
    end
  end

`ifdef DIV_BCD_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of dropped results.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_drop_cnt <= 8'd0;
    end else if (r_in_vld && w_full && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  // Next-state and datapath controls: pop+load in IDLE, N shifts, hold in DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (bcd_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    w_quo_adj = r_quo_acc;
    for (int d = 0; d < QD; d++) begin
      if (r_quo_acc[4*d +: 4] >= 4'd5) w_quo_adj[4*d +: 4] = r_quo_acc[4*d +: 4] + 4'd3;
    end
    w_rem_adj = r_rem_acc;
    for (int d = 0; d < RD; d++) begin
      if (r_rem_acc[4*d +: 4] >= 4'd5) w_rem_adj[4*d +: 4] = r_rem_acc[4*d +: 4] + 4'd3;
    end
    w_quo_shf = (w_quo_adj << 1) | (4*QD)'(r_qbin[N-1]);
    w_rem_shf = (w_rem_adj << 1) | (4*RD)'(r_rbin[N-1]);
  end

  // Conversion datapath; outputs are only updated by the final shift so they hold elsewhere.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_qbin    <= '0;
      r_rbin    <= '0;
      r_quo_acc <= '0;
      r_rem_acc <= '0;
      r_cnt     <= '0;
      r_bcd_quo <= '0;
      r_bcd_rem <= '0;
    end else if (w_load) begin
      r_qbin    <= w_head[WD-1:M];
      r_rbin    <= N'(w_head[M-1:0]);
      r_quo_acc <= '0;
      r_rem_acc <= '0;
      r_cnt     <= '0;
    end else if (w_shift) begin
      r_qbin    <= r_qbin << 1;
      r_rbin    <= r_rbin << 1;
      r_quo_acc <= w_quo_shf;
      r_rem_acc <= w_rem_shf;
      r_cnt     <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_bcd_quo <= w_quo_shf;
        r_bcd_rem <= w_rem_shf;
      end
    end
  end

  assign bcd_vld = (r_state == DONE);
  assign bcd_quo = r_bcd_quo;
  assign bcd_rem = r_bcd_rem;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_div_bcd_conv.sv
// Self-checking bench for div_bcd_conv against an arithmetic BCD reference and an in-order scoreboard.
// Latency: checks the N+2 cycle result latency and one-cycle valid under continuous ready.
// Backpressure: drives bcd_rdy always-high, held-low and random to exercise holding and drops.
module tb_div_bcd_conv;

  localparam int N   = 8;
  localparam int M   = 5;
  localparam int QD  = (N * 77) / 256 + 1;
  localparam int RD  = (M * 77) / 256 + 1;
  localparam int LAT = N + 2;

  logic            clk;
  logic            rstn;
  logic            res_rdy;
  logic [N-1:0]    merchant;
  logic [M-1:0]    remainder;
  logic            bcd_vld;
  logic            bcd_rdy;
  logic [4*QD-1:0] bcd_quo;
  logic [4*RD-1:0] bcd_rem;
  logic            ovf;
`ifdef DIV_BCD_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
  int exp_m_q[$];
  int exp_r_q[$];

  div_bcd_conv #(.N(N), .M(M), .DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .res_rdy   (res_rdy),
    .merchant  (merchant),
    .remainder (remainder),
    .bcd_vld   (bcd_vld),
    .bcd_rdy   (bcd_rdy),
    .bcd_quo   (bcd_quo),
    .bcd_rem   (bcd_rem),
`ifdef DIV_BCD_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain division, least significant digit lowest.
  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] res = '0;
    int x = v;
    for (int d = 0; d < nd; d++) begin
      res[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  // Downstream ready generator.
  initial begin
    bcd_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bcd_rdy = 1'b1;
        1:       bcd_rdy = 1'($urandom_range(0, 1));
        default: bcd_rdy = 1'b0;
      endcase
    end
  end

  // Output monitor: every presented result must match the oldest expected one.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bcd_vld === 1'b1) begin
      if (exp_m_q.size() == 0) begin
        check_val("unexpected_vld", 32'(bcd_vld), 32'd0);
      end else begin
        check_val("bcd_quo", 32'(bcd_quo), to_bcd(exp_m_q[0], QD));
        check_val("bcd_rem", 32'(bcd_rem), to_bcd(exp_r_q[0], RD));
        if (bcd_rdy === 1'b1) begin
          void'(exp_m_q.pop_front());
          void'(exp_r_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input int r, input bit keep);
    res_rdy   = 1'b1;
    merchant  = N'(m);
    remainder = M'(r);
    if (keep) begin
      exp_m_q.push_back(m);
      exp_r_q.push_back(r);
    end
    @(posedge clk);
    #1;
    res_rdy = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input bit pulse_in);
    rstn      = 1'b0;
    res_rdy   = pulse_in;
    merchant  = 8'd99;
    remainder = 5'd7;
    repeat (cycles) @(posedge clk);
    #1;
    res_rdy = 1'b0;
    exp_m_q.delete();
    exp_r_q.delete();
    check_val("rst_vld", 32'(bcd_vld), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_quo", 32'(bcd_quo), 32'd0);
    check_val("rst_rem", 32'(bcd_rem), 32'd0);
`ifdef DIV_BCD_DROP_CNT_EN
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rstn = 1'b1;
  endtask

  // Single result into an idle converter: latency, values, one-cycle valid.
  task automatic send_timed(input int m, input int r, input logic [31:0] eq, input logic [31:0] er);
    int lat = 0;
    drive(m, r, 1'b1);
    while (bcd_vld !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'(LAT));
    check_val("quo_direct", 32'(bcd_quo), eq);
    check_val("rem_direct", 32'(bcd_rem), er);
    @(posedge clk);
    #1;
    check_val("vld_one_cycle", 32'(bcd_vld), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_m_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val(tag, 32'(exp_m_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    int sent;
    int guard;
    rstn      = 1'b0;
    res_rdy   = 1'b0;
    merchant  = '0;
    remainder = '0;
    #1;

    // Reset with a coincident res_rdy pulse: nothing may come out.
    apply_reset(3, 1'b1);
    idle(25);
    check_val("no_out_after_rst_pulse", 32'(bcd_vld), 32'd0);

    // Directed conversions and latency.
    rdy_mode = 0;
    idle(2);
    send_timed(3, 8, 32'h003, 32'h08);
    idle(5);
    send_timed(255, 31, 32'h255, 32'h31);
    idle(5);

    // Full sweep at the nominal rate.
    for (int m = 0; m < 256; m++) begin
      drive(m, m % 32, 1'b1);
      idle(9);
    end
    wait_drain("sweep_drain");
    check_val("sweep_ovf", 32'(ovf), 32'd0);

    // Six back-to-back results with downstream stalled: five kept, sixth dropped.
    rdy_mode = 2;
    idle(2);
    for (int i = 0; i < 6; i++) drive(10 + i * 37, i * 5 + 1, (i < 5));
    idle(30);
    check_val("ovf_set", 32'(ovf), 32'd1);
    check_val("held_vld", 32'(bcd_vld), 32'd1);
`ifdef DIV_BCD_DROP_CNT_EN
    check_val("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
    rdy_mode = 0;
    wait_drain("ovf_drain");
    idle(30);
    check_val("ovf_sticky", 32'(ovf), 32'd1);

    // Reset in the middle of a conversion with one more entry queued.
    drive(123, 17, 1'b1);
    drive(200, 3, 1'b1);
    idle(4);
    apply_reset(1, 1'b0);
    idle(30);
    check_val("fifo_empty_after_rst", 32'(bcd_vld), 32'd0);
    send_timed(77, 29, 32'h077, 32'h29);
    idle(3);

    // Random traffic with random downstream stalls, never more than four outstanding.
    rdy_mode = 1;
    x0       = n_xfer;
    sent     = 0;
    guard    = 0;
    while (sent < 150 && guard < 20000) begin
      guard++;
      if (exp_m_q.size() < 4 && $urandom_range(0, 2) != 0) begin
        drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 1'b1);
        sent++;
      end else begin
        idle(1);
      end
    end
    check_val("rand_sent", 32'(sent), 32'd150);
    wait_drain("rand_drain");
    check_val("rand_xfers", 32'(n_xfer - x0), 32'(sent));
    check_val("rand_ovf", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
